cmp_lock_ctrl: RTL and testbench
================================

Name: cmp_lock_ctrl

Overview:
Sequential code-lock controller that time-shares one external 4-bit equality comparator (A==B -> Q) to check a multi-digit entry against a stored code. Digits arrive one per valid/ready handshake. Each digit is compared in its own cycle. The verdict is given only after the full sequence, so a failed attempt does not reveal which digit was wrong. The block adds retry counting, a timed lockout and code reprogramming while unlocked. It sits between the keypad front end and the comparator cell.

Parameters:
DIGITS, 4, number of code digits per attempt
W, 4, digit width; must match the comparator width
MAX_TRIES, 3, consecutive failed attempts that trigger lockout
LOCKOUT_CYCLES, 16, lockout duration in clk cycles
RESET_CODE, 16'h1234, code loaded at reset (DIGITS*W bits); the first entered digit is the MS nibble

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  key_data valid
key_data  in  W  entered digit
key_ready  out  1  controller accepts a digit this cycle
lock  in  1  relock request, sampled in UNLOCKED
prog_en  in  1  enter code programming, sampled in UNLOCKED
cmp_a  out  W  comparator input A, registered
cmp_b  out  W  comparator input B, registered
cmp_eq  in  1  comparator output Q
unlocked  out  1  lock open
alarm  out  1  lockout active
fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failed attempts
digit_idx  out  $clog2(DIGITS)  index of the next digit expected

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=ENTRY, digit_idx=0, fail_cnt=0.
  - unlocked=0, alarm=0, cmp_a=cmp_b=0, mismatch flag=0.
  - code register=RESET_CODE. A programmed code is lost on reset.
  - Reset mid-sequence aborts the attempt with no verdict.
- Handshake: a transfer occurs when key_valid && key_ready. key_ready=1 only in ENTRY and PROG. The producer holds key_data while ready=0.
- ENTRY: on transfer, cmp_a<=key_data, cmp_b<=code[digit_idx], then go to CHECK.
- CHECK (exactly 1 cycle, key_ready=0):
  - Sample cmp_eq. The comparator is combinational on the registered cmp_a/cmp_b.
  - mismatch <= mismatch | ~cmp_eq.
  - If digit_idx<DIGITS-1: digit_idx++, go to ENTRY.
  - If digit_idx==DIGITS-1, the verdict uses mismatch including the current digit:
    - pass: go to UNLOCKED, fail_cnt=0.
    - fail with fail_cnt+1<MAX_TRIES: fail_cnt++, go to ENTRY.
    - fail with fail_cnt+1==MAX_TRIES: fail_cnt=MAX_TRIES, go to LOCKOUT, load timer=LOCKOUT_CYCLES-1.
  - In all verdict cases digit_idx=0 and mismatch=0.
- Latency: last digit accepted in cycle N; CHECK in N+1; unlocked or alarm high from N+2.
- cmp_a/cmp_b hold their value outside the load cycle.
- UNLOCKED: unlocked=1, key_ready=0.
  - lock=1: go to ENTRY.
  - else prog_en=1: go to PROG, digit_idx=0.
  - lock and prog_en together: lock wins.
- PROG: unlocked stays 1, key_ready=1, comparator not used.
  - Each transfer writes code[digit_idx] and increments digit_idx.
  - After the DIGITS-th write: go to ENTRY (locked), digit_idx=0. The new code is effective for the next attempt.
  - lock in PROG is ignored; programming always completes.
- LOCKOUT: alarm=1, key_ready=0, keys ignored. Timer decrements each cycle.
  - Timer==0: go to ENTRY, alarm=0, fail_cnt=0. Total time in LOCKOUT is LOCKOUT_CYCLES cycles.
- unlocked and alarm are registered outputs decoded from state. They are never high simultaneously.
- fail_cnt persists across attempts. It is cleared only by a pass, the end of lockout, or reset.

Test Plan:
- Reset, then enter 1,2,3,4 (one per cycle, valid held) -> key_ready low in each CHECK; cmp_a/cmp_b = (1,1),(2,2),(3,3),(4,4); unlocked=1 two cycles after the 4th accept; fail_cnt=0.
- Enter 1,2,9,4 -> no early reject; all 4 digits accepted; unlocked=0, fail_cnt=1, digit_idx=0, back in ENTRY.
- Three wrong attempts (0,0,0,0 ×3) -> alarm=1 after the 3rd verdict, fail_cnt=3, key_ready=0 and key_valid ignored for exactly 16 cycles; then alarm=0, fail_cnt=0, key_ready=1.
- Unlock, pulse prog_en, write A,B,C,D -> unlocked=0 after the 4th write; code 1,2,3,4 now fails; A,B,C,D unlocks.
- In UNLOCKED assert lock and prog_en in the same cycle -> ENTRY, unlocked=0, PROG not entered.
- After 2 digits of an attempt (and after reprogramming), drive rst_n=0 asynchronously -> all outputs at reset values immediately; code reverts to 1,2,3,4; next 1,2,3,4 unlocks.

Source files
------------

// File: rtl/cmp_lock_ctrl_if.sv
// rtl/cmp_lock_ctrl_if.sv - keypad digit stream and shared comparator link
interface cmp_lock_ctrl_if #(
    parameter int W = 4
);
    logic         key_valid;
    logic [W-1:0] key_data;
    logic         key_ready;
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         cmp_eq;

    // master: the lock controller; slave: keypad front end plus comparator cell
    modport master (
        input  key_valid,
        input  key_data,
        output key_ready,
        output cmp_a,
        output cmp_b,
        input  cmp_eq
    );

    modport slave (
        output key_valid,
        output key_data,
        input  key_ready,
        input  cmp_a,
        input  cmp_b,
        output cmp_eq
    );
endinterface

// File: rtl/cmp_lock_ctrl.sv
// rtl/cmp_lock_ctrl.sv - code lock checking one digit per cycle on a shared comparator
module cmp_lock_ctrl #(
    parameter int                    DIGITS         = 4,
    parameter int                    W              = 4,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    LOCKOUT_CYCLES = 16,
    parameter logic [DIGITS*W-1:0]   RESET_CODE     = 16'h1234,
    localparam int                   IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int                   FW = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    cmp_lock_ctrl_if.master kb,
    input  logic          lock,
    input  logic          prog_en,
    output logic          unlocked,
    output logic          alarm,
    output logic [FW-1:0] fail_cnt,
    output logic [IW-1:0] digit_idx
);
    localparam int             TW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [IW-1:0]  LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0]  MAX_F  = FW'(MAX_TRIES);
    localparam logic [TW-1:0]  T_LOAD = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CHECK,
        S_UNLOCKED,
        S_PROG,
        S_LOCKOUT
    } state_t;

    state_t        state;
    logic [W-1:0]  code [DIGITS];
    logic          mismatch;
    logic          mismatch_nx;
    logic [TW-1:0] timer;
    logic          xfer;

    assign kb.key_ready = (state == S_ENTRY) || (state == S_PROG);
    assign xfer         = kb.key_valid && kb.key_ready;
    // The verdict must include the digit being compared this cycle.
    assign mismatch_nx  = mismatch | ~kb.cmp_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ENTRY;
            digit_idx <= '0;
            fail_cnt  <= '0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
            kb.cmp_a  <= '0;
            kb.cmp_b  <= '0;
            mismatch  <= 1'b0;
            timer     <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                code[i] <= RESET_CODE[(DIGITS-1-i)*W +: W];
            end
        end else begin
            case (state)
                S_ENTRY: begin
                    if (xfer) begin
                        kb.cmp_a <= kb.key_data;
                        kb.cmp_b <= code[digit_idx];
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (digit_idx != LAST) begin
                        mismatch  <= mismatch_nx;
                        digit_idx <= digit_idx + IW'(1);
                        state     <= S_ENTRY;
                    end else begin
                        mismatch  <= 1'b0;
                        digit_idx <= '0;
                        if (!mismatch_nx) begin
                            fail_cnt <= '0;
                            unlocked <= 1'b1;
                            state    <= S_UNLOCKED;
                        end else if ((fail_cnt + FW'(1)) < MAX_F) begin
                            fail_cnt <= fail_cnt + FW'(1);
                            state    <= S_ENTRY;
                        end else begin
                            fail_cnt <= MAX_F;
                            alarm    <= 1'b1;
                            timer    <= T_LOAD;
                            state    <= S_LOCKOUT;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (lock) begin
                        unlocked <= 1'b0;
                        state    <= S_ENTRY;
                    end else if (prog_en) begin
                        digit_idx <= '0;
                        state     <= S_PROG;
                    end
                end
                S_PROG: begin
                    // Programming always runs to completion; lock is not sampled here.
                    if (xfer) begin
                        code[digit_idx] <= kb.key_data;
                        if (digit_idx == LAST) begin
                            digit_idx <= '0;
                            unlocked  <= 1'b0;
                            state     <= S_ENTRY;
                        end else begin
                            digit_idx <= digit_idx + IW'(1);
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        state    <= S_ENTRY;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state     <= S_ENTRY;
                    unlocked  <= 1'b0;
                    alarm     <= 1'b0;
                    digit_idx <= '0;
                    mismatch  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_lock_ctrl.sv
// tb/tb_cmp_lock_ctrl.sv - directed-vector bench for cmp_lock_ctrl
`timescale 1ns/1ps
module tb_cmp_lock_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock;
    logic       prog_en;
    logic       key_valid;
    logic [3:0] key_data;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic [1:0] digit_idx;

    int n_vec = 0;
    int n_err = 0;

    cmp_lock_ctrl_if #(.W(4)) bus ();

    assign bus.key_valid = key_valid;
    assign bus.key_data  = key_data;
    assign bus.cmp_eq    = (bus.cmp_a == bus.cmp_b);

    cmp_lock_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kb        (bus),
        .lock      (lock),
        .prog_en   (prog_en),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the digit was accepted.
    task automatic key(input logic [3:0] d);
        int n = 0;
        key_valid = 1'b1;
        key_data  = d;
        while (!bus.key_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("key_wait", 32'(n < 40), 32'd1);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Four digits then one more cycle, so the verdict is visible on return.
    task automatic attempt(input logic [15:0] c);
        key(c[15:12]);
        key(c[11:8]);
        key(c[7:4]);
        key(c[3:0]);
        @(negedge clk);
    endtask

    task automatic relock();
        lock = 1'b1;
        @(negedge clk);
        lock = 1'b0;
    endtask

    initial begin
        int  cyc;
        logic rdy_seen;
        rst_n     = 1'b0;
        lock      = 1'b0;
        prog_en   = 1'b0;
        key_valid = 1'b0;
        key_data  = 4'h0;
        @(negedge clk);
        check("rst_unlocked", 32'(unlocked), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("rst_digit_idx", 32'(digit_idx), 32'd0);
        check("rst_cmp_a", 32'(bus.cmp_a), 32'd0);
        check("rst_cmp_b", 32'(bus.cmp_b), 32'd0);
        check("rst_key_ready", 32'(bus.key_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct code 1,2,3,4
        key(4'h1);
        check("c1_ready", 32'(bus.key_ready), 32'd0);
        check("c1_a", 32'(bus.cmp_a), 32'h1);
        check("c1_b", 32'(bus.cmp_b), 32'h1);
        key(4'h2);
        check("c2_ready", 32'(bus.key_ready), 32'd0);
        check("c2_a", 32'(bus.cmp_a), 32'h2);
        check("c2_b", 32'(bus.cmp_b), 32'h2);
        key(4'h3);
        check("c3_a", 32'(bus.cmp_a), 32'h3);
        check("c3_b", 32'(bus.cmp_b), 32'h3);
        key(4'h4);
        check("c4_ready", 32'(bus.key_ready), 32'd0);
        check("c4_a", 32'(bus.cmp_a), 32'h4);
        check("c4_b", 32'(bus.cmp_b), 32'h4);
        check("c4_unlocked_n1", 32'(unlocked), 32'd0);
        @(negedge clk);
        check("pass_unlocked", 32'(unlocked), 32'd1);
        check("pass_fail_cnt", 32'(fail_cnt), 32'd0);
        check("pass_ready", 32'(bus.key_ready), 32'd0);
        relock();
        check("relock_unlocked", 32'(unlocked), 32'd0);
        check("relock_ready", 32'(bus.key_ready), 32'd1);

        // Wrong third digit: no early reject
        key(4'h1);
        key(4'h2);
        key(4'h9);
        check("w3_a", 32'(bus.cmp_a), 32'h9);
        check("w3_b", 32'(bus.cmp_b), 32'h3);
        @(negedge clk);
        check("w3_no_early", 32'(digit_idx), 32'd3);
        check("w3_ready", 32'(bus.key_ready), 32'd1);
        key(4'h4);
        @(negedge clk);
        check("w_unlocked", 32'(unlocked), 32'd0);
        check("w_fail_cnt", 32'(fail_cnt), 32'd1);
        check("w_digit_idx", 32'(digit_idx), 32'd0);
        check("w_ready", 32'(bus.key_ready), 32'd1);

        // Clear the count with a pass, then three wrong attempts into lockout
        attempt(16'h1234);
        check("clr_unlocked", 32'(unlocked), 32'd1);
        check("clr_fail_cnt", 32'(fail_cnt), 32'd0);
        relock();
        attempt(16'h0000);
        check("f1_fail_cnt", 32'(fail_cnt), 32'd1);
        attempt(16'h0000);
        check("f2_fail_cnt", 32'(fail_cnt), 32'd2);
        check("f2_alarm", 32'(alarm), 32'd0);
        attempt(16'h0000);
        check("f3_alarm", 32'(alarm), 32'd1);
        check("f3_fail_cnt", 32'(fail_cnt), 32'd3);
        check("f3_unlocked", 32'(unlocked), 32'd0);
        key_valid = 1'b1;
        key_data  = 4'h1;
        cyc       = 0;
        rdy_seen  = 1'b0;
        while (alarm && cyc < 40) begin
            if (bus.key_ready) rdy_seen = 1'b1;
            cyc++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("lockout_len", 32'(cyc), 32'd16);
        check("lockout_ready", 32'(rdy_seen), 32'd0);
        check("lockout_idx", 32'(digit_idx), 32'd0);
        check("post_alarm", 32'(alarm), 32'd0);
        check("post_fail_cnt", 32'(fail_cnt), 32'd0);
        check("post_ready", 32'(bus.key_ready), 32'd1);

        // Reprogram to A,B,C,D
        attempt(16'h1234);
        check("p_unlocked", 32'(unlocked), 32'd1);
        prog_en = 1'b1;
        @(negedge clk);
        prog_en = 1'b0;
        check("prog_unlocked", 32'(unlocked), 32'd1);
        check("prog_ready", 32'(bus.key_ready), 32'd1);
        check("prog_idx0", 32'(digit_idx), 32'd0);
        key(4'hA);
        check("prog_idx1", 32'(digit_idx), 32'd1);
        check("prog_ready1", 32'(bus.key_ready), 32'd1);
        key(4'hB);
        key(4'hC);
        check("prog_idx3", 32'(digit_idx), 32'd3);
        check("prog_unl3", 32'(unlocked), 32'd1);
        key(4'hD);
        check("prog_done_unl", 32'(unlocked), 32'd0);
        check("prog_done_idx", 32'(digit_idx), 32'd0);
        attempt(16'h1234);
        check("old_code_unl", 32'(unlocked), 32'd0);
        check("old_code_fail", 32'(fail_cnt), 32'd1);
        attempt(16'hABCD);
        check("new_code_unl", 32'(unlocked), 32'd1);
        check("new_code_fail", 32'(fail_cnt), 32'd0);

        // lock and prog_en together: lock wins
        lock    = 1'b1;
        prog_en = 1'b1;
        @(negedge clk);
        lock    = 1'b0;
        prog_en = 1'b0;
        check("both_unlocked", 32'(unlocked), 32'd0);
        key(4'hA);
        check("both_is_entry", 32'(bus.key_ready), 32'd0);
        check("both_cmp_a", 32'(bus.cmp_a), 32'hA);
        @(negedge clk);
        key(4'hB);
        key(4'hC);
        key(4'hD);
        @(negedge clk);
        check("both_code_kept", 32'(unlocked), 32'd1);
        relock();

        // Asynchronous reset mid-attempt reverts the code
        attempt(16'h0000);
        check("pre_rst_fail", 32'(fail_cnt), 32'd1);
        key(4'hA);
        key(4'hB);
        @(negedge clk);
        check("pre_rst_idx", 32'(digit_idx), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_idx", 32'(digit_idx), 32'd0);
        check("arst_fail", 32'(fail_cnt), 32'd0);
        check("arst_cmp_a", 32'(bus.cmp_a), 32'd0);
        check("arst_cmp_b", 32'(bus.cmp_b), 32'd0);
        check("arst_unl", 32'(unlocked), 32'd0);
        check("arst_alarm", 32'(alarm), 32'd0);
        check("arst_ready", 32'(bus.key_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        attempt(16'h1234);
        check("rst_code_unl", 32'(unlocked), 32'd1);
        check("rst_code_fail", 32'(fail_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
